// File: rtl/light_pkg.sv
// Shared constants, FSM state type and direction helper for the light level scheduler.
package light_pkg;

  localparam int LVL_OFF        = 0;
  localparam int LVL_MAX        = 4;
  localparam int DEF_RAMP_TICKS = 50;
  localparam int DEF_IDLE_TICKS = 30000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } state_t;

  // Where the FSM should sit given the target and the driven level.
  function automatic state_t select_dir(input int tgt, input int cur);
    if (tgt > cur)      return RAMP_UP;
    else if (tgt < cur) return RAMP_DOWN;
    else                return IDLE;
  endfunction

endpackage

// File: rtl/light_level_scheduler_tick_timer.sv
// tick_timer: reloadable down-counter advanced by a tick enable, with a synchronous
// clear back to CLEAR_VAL and a terminal pulse on the enabled cycle at zero.
module tick_timer #(
  parameter int             W         = 16,
  parameter logic [W-1:0]   CLEAR_VAL = '0,
  parameter logic [W-1:0]   LOAD_VAL  = '0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_en,
  output logic o_terminal
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count <= CLEAR_VAL;
    end else if (i_clear) begin
      r_count <= CLEAR_VAL;
    end else if (i_en) begin
      r_count <= (r_count == '0) ? LOAD_VAL : r_count - W'(1);
    end
  end

  // Clear wins over a terminal event on the same cycle.
  assign o_terminal = i_en && !i_clear && (r_count == '0);

endmodule

// File: rtl/light_level_scheduler.sv
// Fades the driven light level toward a button-controlled target, one level per ramp period.
// Optional idle auto-off is built when LIGHT_IDLE_TIMEOUT_EN is defined.
module light_level_scheduler
  import light_pkg::*;
#(
  parameter int MAX_LEVEL  = LVL_MAX,
  parameter int LEVEL_W    = 3,
  parameter int RAMP_TICKS = DEF_RAMP_TICKS,
  parameter int IDLE_TICKS = DEF_IDLE_TICKS,
  parameter int TICK_W     = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_btn_up,
  input  logic               i_btn_down,
  input  logic               i_btn_off,
  output logic [LEVEL_W-1:0] o_lightState,
  output logic [LEVEL_W-1:0] o_target,
  output logic               o_ramping,
  output logic               o_timeout
);

  localparam logic [LEVEL_W-1:0] C_MAX = LEVEL_W'(MAX_LEVEL);
  localparam logic [LEVEL_W-1:0] C_OFF = LEVEL_W'(LVL_OFF);

  if (RAMP_TICKS < 1 || IDLE_TICKS < 1 || MAX_LEVEL >= 2**LEVEL_W ||
      RAMP_TICKS - 1 >= 2**TICK_W || IDLE_TICKS - 1 >= 2**TICK_W) begin : g_cfg_check
    $error("light_level_scheduler: illegal parameter combination");
  end

  logic [LEVEL_W-1:0] r_cur, r_tgt, w_cur_next, w_tgt_next;
  state_t             r_state, w_state_next;
  logic               r_timeout;
  logic               w_up, w_down, w_activity, w_step, w_timeout;

  // Simultaneous up+down cancels out and is not treated as activity.
  assign w_up       = i_btn_up & ~i_btn_down;
  assign w_down     = i_btn_down & ~i_btn_up;
  assign w_activity = i_btn_off | w_up | w_down;

  always_comb begin
    w_tgt_next = r_tgt;
    if (i_btn_off)                 w_tgt_next = C_OFF;
    else if (w_up && r_tgt != C_MAX) w_tgt_next = r_tgt + LEVEL_W'(1);
    else if (w_down && r_tgt != C_OFF) w_tgt_next = r_tgt - LEVEL_W'(1);
    else if (w_timeout)            w_tgt_next = C_OFF;
  end

  tick_timer #(
    .W         (TICK_W),
    .CLEAR_VAL ('0),
    .LOAD_VAL  (TICK_W'(RAMP_TICKS - 1))
  ) u_ramp_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_clear    (r_state == IDLE),
    .i_en       (i_tick && r_state != IDLE),
    .o_terminal (w_step)
  );

`ifdef LIGHT_IDLE_TIMEOUT_EN
  // Counts down from IDLE_TICKS-1, so the terminal fires on the IDLE_TICKS-th quiet tick.
  tick_timer #(
    .W         (TICK_W),
    .CLEAR_VAL (TICK_W'(IDLE_TICKS - 1)),
    .LOAD_VAL  (TICK_W'(IDLE_TICKS - 1))
  ) u_idle_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_clear    (w_activity || r_tgt == C_OFF),
    .i_en       (i_tick),
    .o_terminal (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_cur_next   = r_cur;
    if (r_state == IDLE) begin
      w_state_next = select_dir(int'(r_tgt), int'(r_cur));
    end else if (r_tgt == r_cur) begin
      w_state_next = IDLE;
    end else if (w_step) begin
      // Direction comes from the target as it stood before this edge's button update.
      w_cur_next   = (r_tgt > r_cur) ? r_cur + LEVEL_W'(1) : r_cur - LEVEL_W'(1);
      w_state_next = select_dir(int'(r_tgt), int'(w_cur_next));
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_cur     <= C_OFF;
      r_tgt     <= C_OFF;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cur     <= w_cur_next;
      r_tgt     <= w_tgt_next;
      r_timeout <= w_timeout;
    end
  end

  assign o_lightState = r_cur;
  assign o_target     = r_tgt;
  assign o_ramping    = (r_state != IDLE);
  assign o_timeout    = r_timeout;

endmodule

// File: tb/tb_light_level_scheduler.sv
// Directed bench for light_level_scheduler with RAMP_TICKS=3 and IDLE_TICKS=5.
// Idle timeout scenarios run when LIGHT_IDLE_TIMEOUT_EN is defined.
module tb_light_level_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick, up, down, off;
  logic [2:0] light, target;
  logic       ramping, timeout;

  int checks = 0;
  int errors = 0;
  int max_cur;
  logic timeout_seen;

  always #5 clk = ~clk;

  light_level_scheduler #(
    .MAX_LEVEL (4),
    .LEVEL_W   (3),
    .RAMP_TICKS(3),
    .IDLE_TICKS(5),
    .TICK_W    (16)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_tick      (tick),
    .i_btn_up    (up),
    .i_btn_down  (down),
    .i_btn_off   (off),
    .o_lightState(light),
    .o_target    (target),
    .o_ramping   (ramping),
    .o_timeout   (timeout)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs, then sample 1 time unit after the edge.
  task automatic cyc(input logic t, input logic u, input logic d, input logic o);
    tick = t; up = u; down = d; off = o;
    @(posedge clk);
    #1;
    tick = 1'b0; up = 1'b0; down = 1'b0; off = 1'b0;
    if (timeout === 1'b1) timeout_seen = 1'b1;
    if (int'(light) > max_cur) max_cur = int'(light);
  endtask

  initial begin
    int exp_fade [7];
    exp_fade = '{2, 2, 2, 1, 1, 1, 0};
    rst = 1'b1; tick = 1'b0; up = 1'b0; down = 1'b0; off = 1'b0;
    timeout_seen = 1'b0; max_cur = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_light", light, 0);
    check("reset_target", target, 0);
    check("reset_ramping", ramping, 0);
    check("reset_timeout", timeout, 0);
    rst = 1'b0;

    // Reset during a ramp with a stepping tick on the same edge: nothing steps.
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    check("pre_reset_ramping", ramping, 1);
    tick = 1'b1; rst = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    check("midramp_reset_light", light, 0);
    check("midramp_reset_target", target, 0);
    check("midramp_reset_ramping", ramping, 0);
    rst = 1'b0;
    cyc(0, 0, 0, 0);
    $display("txn reset_midramp light=%0d target=%0d", light, target);

    // Two up pulses: step on tick 1 and tick 4.
    cyc(0, 1, 0, 0);
    check("up1_target", target, 1);
    cyc(0, 1, 0, 0);
    check("up2_target", target, 2);
    check("up2_ramping", ramping, 1);
    cyc(1, 0, 0, 0);
    check("t1_light", light, 1);
    check("t1_ramping", ramping, 1);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check("t3_light", light, 1);
    cyc(1, 0, 0, 0);
    check("t4_light", light, 2);
    check("t4_ramping", ramping, 0);
    $display("txn two_up light=%0d target=%0d", light, target);

    // Six up pulses saturate the target at 4.
    repeat (6) cyc(0, 1, 0, 0);
    check("sat_target", target, 4);
    max_cur = 0;
    repeat (10) cyc(1, 0, 0, 0);
    check("sat_light", light, 4);
    check("sat_max_light", max_cur, 4);
    check("sat_ramping", ramping, 0);
    $display("txn saturate light=%0d target=%0d", light, target);

    // Down to level 3, then off fades one level per ramp period.
    cyc(0, 0, 1, 0);
    check("down_target", target, 3);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check("lvl3_light", light, 3);
    cyc(0, 0, 0, 1);
    check("off_target", target, 0);
    cyc(0, 0, 0, 0);
    for (int k = 0; k < 7; k++) begin
      cyc(1, 0, 0, 0);
      check($sformatf("fade_tick%0d", k + 1), light, 16'(exp_fade[k]));
    end
    check("fade_ramping", ramping, 0);
    $display("txn off_fade light=%0d target=%0d", light, target);

    // Mid-ramp toward 4, pull target back to 1 while at level 2.
    repeat (4) cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    repeat (4) cyc(1, 0, 0, 0);
    check("mid_light", light, 2);
    repeat (3) cyc(0, 0, 1, 0);
    check("mid_target", target, 1);
    max_cur = 0;
    repeat (4) cyc(1, 0, 0, 0);
    check("mid_final_light", light, 1);
    check("mid_max_light", max_cur, 2);
    check("mid_ramping", ramping, 0);
    $display("txn retarget light=%0d target=%0d", light, target);

    // Conflicting button combinations.
    cyc(0, 1, 1, 0);
    check("updown_target", target, 1);
    cyc(0, 1, 0, 1);
    check("offup_target", target, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check("combo_light", light, 0);
    check("combo_ramping", ramping, 0);
    $display("txn combos light=%0d target=%0d", light, target);

`ifdef LIGHT_IDLE_TIMEOUT_EN
    // Quiet at level 2: timeout on the 5th tick, then fade to 0.
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    timeout_seen = 1'b0;
    repeat (4) cyc(1, 0, 0, 0);
    check("to_pre_light", light, 2);
    check("to_pre_seen", timeout_seen, 0);
    cyc(1, 0, 0, 0);
    check("to_pulse", timeout, 1);
    check("to_target", target, 0);
    cyc(0, 0, 0, 0);
    check("to_pulse_end", timeout, 0);
    repeat (4) cyc(1, 0, 0, 0);
    check("to_fade_light", light, 0);
    $display("txn idle_timeout light=%0d target=%0d", light, target);

    // Same, but an up pulse on tick 4 keeps the light on and raises it.
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    timeout_seen = 1'b0;
    repeat (3) cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    check("keep_light", light, 2);
    check("keep_target", target, 3);
    repeat (3) cyc(1, 0, 0, 0);
    check("keep_final_light", light, 3);
    check("keep_seen", timeout_seen, 0);
    $display("txn idle_kept light=%0d target=%0d", light, target);
`else
    // Without the idle timer the level stays put indefinitely.
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    timeout_seen = 1'b0;
    repeat (12) cyc(1, 0, 0, 0);
    check("noto_light", light, 2);
    check("noto_target", target, 2);
    check("noto_seen", timeout_seen, 0);
    $display("txn no_timeout light=%0d target=%0d", light, target);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
